// File: rtl/cnn_layer_sequencer_if.sv
// Handshake and control bundle between the frame sequencer and its neighbours:
// the input loader (frame_*), the layer engines (layer_*) and the result
// consumer (result_*), plus status outputs.
interface cnn_layer_sequencer_if #(
  parameter int NUM_LAYERS = 4,
  parameter int CNT_W      = 32
);
  localparam int LW = $clog2(NUM_LAYERS) + 1;

  logic                  frame_valid;
  logic                  frame_ready;
  logic [NUM_LAYERS-1:0] layer_start;
  logic [NUM_LAYERS-1:0] layer_done;
  logic                  result_valid;
  logic                  result_ready;
  logic                  busy;
  logic [LW-1:0]         cur_layer;
  logic                  timeout_err;
  logic [CNT_W-1:0]      cycle_count;

  // Sequencer side.
  modport master (
    input  frame_valid, layer_done, result_ready,
    output frame_ready, layer_start, result_valid, busy,
           cur_layer, timeout_err, cycle_count
  );

  // Environment side (loader, layer engines, consumer).
  modport slave (
    output frame_valid, layer_done, result_ready,
    input  frame_ready, layer_start, result_valid, busy,
           cur_layer, timeout_err, cycle_count
  );
endinterface

// File: rtl/cnn_layer_sequencer.sv
// Frame-level controller for the CNN pipeline. Accepts a frame, launches each
// layer engine in turn with a one-cycle start pulse, waits for that layer's
// done pulse, then holds the result until the consumer takes it. A per-layer
// watchdog aborts a stuck frame with a sticky error, and a saturating counter
// reports how many cycles the frame spent in LAUNCH/WAIT.
// Every output comes straight from a flop so layer_start is glitch-free.
module cnn_layer_sequencer #(
  parameter int NUM_LAYERS     = 4,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int CNT_W          = 32
) (
  input logic                   clk,
  input logic                   reset,
  cnn_layer_sequencer_if.master bus
);

  localparam int LW = $clog2(NUM_LAYERS) + 1;
  localparam logic [LW-1:0]    LAST_LAYER = LW'(NUM_LAYERS - 1);
  localparam logic [CNT_W-1:0] WD_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESULT,
    ERROR
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [LW-1:0]         cur_layer;
  logic [LW-1:0]         cur_layer_nxt;
  logic [CNT_W-1:0]      watchdog;
  logic [CNT_W-1:0]      watchdog_nxt;
  logic [CNT_W-1:0]      cycle_count;
  logic                  timeout_err;
  logic                  accept;
  logic                  done_sel;
  logic [NUM_LAYERS-1:0] start_vec;

  logic                  frame_ready_q;
  logic                  result_valid_q;
  logic                  busy_q;
  logic [NUM_LAYERS-1:0] layer_start_q;

  // A frame is taken only in IDLE, which is exactly when frame_ready is high.
  assign accept = (state == IDLE) && bus.frame_valid;

  // Select the done bit of the layer being waited on, and build the one-hot
  // start vector for the layer that will be launched next cycle.
  always_comb begin
    done_sel  = 1'b0;
    start_vec = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (cur_layer == LW'(i)) done_sel = bus.layer_done[i];
      if (cur_layer_nxt == LW'(i)) start_vec[i] = 1'b1;
    end
  end

  // Next-state, next layer index and watchdog update.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    state_nxt     = state;
    cur_layer_nxt = cur_layer;
    watchdog_nxt  = watchdog;
    unique case (state)
      IDLE: begin
        if (accept) begin
          cur_layer_nxt = '0;
          state_nxt     = LAUNCH;
        end
      end
      LAUNCH: begin
        // Done pulses are not looked at here; the watchdog restarts per layer.
        watchdog_nxt = '0;
        state_nxt    = WAIT;
      end
      WAIT: begin
        // A done in the expiry cycle takes priority over the timeout.
        if (done_sel) begin
          if (cur_layer == LAST_LAYER) begin
            state_nxt = RESULT;
          end else begin
            cur_layer_nxt = cur_layer + LW'(1);
            state_nxt     = LAUNCH;
          end
        end else if (watchdog == WD_LAST) begin
          state_nxt = ERROR;
        end else begin
          watchdog_nxt = watchdog + CNT_W'(1);
        end
      end
      RESULT: begin
        if (bus.result_ready) state_nxt = IDLE;
      end
      ERROR: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, layer index and watchdog registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cur_layer <= '0;
      watchdog  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      state     <= state_nxt;
      cur_layer <= cur_layer_nxt;
      watchdog  <= watchdog_nxt;
    end
  end

  // Frame cycle counter: cleared on accept, counts LAUNCH/WAIT cycles, saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (accept) begin
      cycle_count <= '0;
    end else if ((state == LAUNCH || state == WAIT) && cycle_count != CNT_MAX) begin
      cycle_count <= cycle_count + CNT_W'(1);
    end
  end

  // Sticky watchdog error: set on leaving ERROR, cleared by the next accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else if (accept) begin
      timeout_err <= 1'b0;
    end else if (state == ERROR) begin
      timeout_err <= 1'b1;
    end
  end

  // Registered decode of the next state into the handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_ready_q  <= 1'b1;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      layer_start_q  <= '0;
    end else begin
      frame_ready_q  <= (state_nxt == IDLE);
      result_valid_q <= (state_nxt == RESULT);
      busy_q         <= (state_nxt != IDLE);
      layer_start_q  <= (state_nxt == LAUNCH) ? start_vec : '0;
    end
  end

  assign bus.frame_ready  = frame_ready_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy_q;
  assign bus.layer_start  = layer_start_q;
  assign bus.cur_layer    = cur_layer;
  assign bus.timeout_err  = timeout_err;
  assign bus.cycle_count  = cycle_count;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Self-checking bench for cnn_layer_sequencer. Layer engines are reactive
// stubs with per-frame latencies; the expected timeline of each frame is
// derived from the latencies with plain arithmetic and compared every cycle.
module tb_cnn_layer_sequencer;

  localparam int NL     = 4;
  localparam int TO     = 8;
  localparam int CW     = 5;
  localparam int LW     = $clog2(NL) + 1;
  localparam int CC_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;

  cnn_layer_sequencer_if #(.NUM_LAYERS(NL), .CNT_W(CW)) bus ();

  cnn_layer_sequencer #(
    .NUM_LAYERS    (NL),
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-frame layer latencies (start->done cycles); values above TO never finish.
  int lat [NL];

  // Status expected to persist in IDLE from the previous frame.
  int prev_err = 0;
  int prev_cur = 0;
  int prev_cc  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_frame_ready"}, bus.frame_ready, 1);
    check({tag, "_result_valid"}, bus.result_valid, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_layer_start"}, bus.layer_start, 0);
    check({tag, "_cur_layer"}, bus.cur_layer, 0);
    check({tag, "_timeout_err"}, bus.timeout_err, 0);
    check({tag, "_cycle_count"}, bus.cycle_count, 0);
  endtask

  // Run one frame. rr_delay: cycles result_valid is held before result_ready.
  // abort_at > 0: assert reset mid-frame in that cycle and return.
  task automatic run_frame(input int rr_delay, input int abort_at);
    int st [NL];
    int done_at [NL];
    int t, end_t, idle_t, err_layer, cur, cc_exp;
    bit is_err;
    bit in_frame, in_tail, is_idle;
    logic [NL-1:0] exp_start, dv, sp;

    // Timeline model: layer i starts one cycle after layer i-1 finished;
    // a layer slower than TO expires after TO wait cycles.
    t = 1;
    is_err = 0;
    err_layer = 0;
    for (int i = 0; i < NL; i++) begin
      st[i] = -1;
      done_at[i] = -1;
    end
    for (int i = 0; i < NL; i++) begin
      st[i] = t;
      if (lat[i] > TO) begin
        is_err = 1;
        err_layer = i;
        t = t + TO + 1;
        break;
      end
      t = t + lat[i] + 1;
    end
    end_t  = t;
    idle_t = is_err ? end_t + 1 : end_t + rr_delay + 1;

    // Cycle 0: idle, offer the frame.
    @(negedge clk);
    check("idle_frame_ready", bus.frame_ready, 1);
    check("idle_busy", bus.busy, 0);
    check("idle_result_valid", bus.result_valid, 0);
    check("idle_layer_start", bus.layer_start, 0);
    check("idle_timeout_err", bus.timeout_err, prev_err);
    check("idle_cur_layer", bus.cur_layer, prev_cur);
    check("idle_cycle_count", bus.cycle_count, prev_cc);
    bus.frame_valid  = 1'b1;
    bus.layer_done   = NL'($urandom);
    bus.result_ready = 1'($urandom);

    for (int n = 1; n <= idle_t; n++) begin
      @(negedge clk);
      exp_start = '0;
      cur = 0;
      for (int i = 0; i < NL; i++) begin
        if (st[i] == n) exp_start[i] = 1'b1;
        if (st[i] != -1 && st[i] <= n) cur = i;
      end
      in_frame = (n < end_t);
      in_tail  = (n >= end_t) && (n < idle_t);
      is_idle  = (n == idle_t);
      cc_exp   = ((n < end_t ? n : end_t) - 1);
      if (cc_exp > CC_MAX) cc_exp = CC_MAX;

      check($sformatf("layer_start@%0d", n), bus.layer_start, exp_start);
      check($sformatf("busy@%0d", n), bus.busy, !is_idle);
      check($sformatf("frame_ready@%0d", n), bus.frame_ready, is_idle);
      check($sformatf("result_valid@%0d", n), bus.result_valid, !is_err && in_tail);
      check($sformatf("cur_layer@%0d", n), bus.cur_layer, cur);
      check($sformatf("timeout_err@%0d", n), bus.timeout_err, is_idle && is_err);
      check($sformatf("cycle_count@%0d", n), bus.cycle_count, cc_exp);

      if (n == abort_at) begin
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("abort");
        bus.frame_valid  = 1'b0;
        bus.layer_done   = '0;
        bus.result_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        prev_err = 0;
        prev_cur = 0;
        prev_cc  = 0;
        return;
      end

      // Layer stubs respond to the start pulse they actually see.
      for (int i = 0; i < NL; i++)
        if (bus.layer_start[i]) done_at[i] = (lat[i] > TO) ? -1 : n + lat[i];
      dv = '0;
      for (int i = 0; i < NL; i++)
        if (done_at[i] == n) dv[i] = 1'b1;
      // Spurious done pulses on any layer not currently being waited on.
      sp = NL'($urandom & $urandom);
      if (in_frame && n != st[cur]) sp[cur] = 1'b0;

      bus.layer_done   = is_idle ? '0 : (dv | sp);
      bus.frame_valid  = is_idle ? 1'b0 : 1'($urandom);
      bus.result_ready = (!is_err && n >= end_t) ? (n == end_t + rr_delay) : 1'($urandom);
      if (is_idle) bus.result_ready = 1'b0;
    end

    prev_err = is_err;
    prev_cur = is_err ? err_layer : NL - 1;
    prev_cc  = (end_t - 1 > CC_MAX) ? CC_MAX : end_t - 1;
  endtask

  initial begin
    reset            = 1'b1;
    bus.frame_valid  = 1'b0;
    bus.layer_done   = '0;
    bus.result_ready = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reference latencies: starts at 1,7,11,19, result at 22, count 21.
    lat = '{5, 3, 7, 2};
    run_frame(0, 0);
    check("t1_cycle_count", prev_cc, 21);

    // Result held for 10 cycles with frame_valid toggling.
    lat = '{2, 1, 4, 3};
    run_frame(10, 0);

    // Layer 1 never finishes: watchdog error, no start for layer 2.
    lat = '{3, TO + 1, 2, 2};
    run_frame(0, 0);
    // Next frame clears the sticky error on accept.
    lat = '{1, 1, 1, 1};
    run_frame(1, 0);

    // Done arriving in the watchdog expiry cycle wins.
    lat = '{TO, TO, 1, TO};
    run_frame(2, 0);

    // Long frame saturates the cycle counter.
    lat = '{8, 8, 8, 8};
    run_frame(0, 0);

    // Reset in the middle of waiting on layer 2, then a clean restart.
    lat = '{2, 2, 5, 2};
    run_frame(0, 1 + 3 + 3 + 2);
    lat = '{3, 2, 1, 4};
    run_frame(0, 0);

    // Randomized frames, including timeouts and saturation.
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < NL; i++) lat[i] = $urandom_range(1, TO + 2);
      run_frame($urandom_range(0, 5), 0);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
